// File: rtl/systolic_pe_array.sv
// Output-stationary TxT systolic MAC array: A flows east, B flows south, each PE
// accumulates its dot product until cleared; a drain pulse snapshots every accumulator.
module systolic_pe_array #(
  parameter int W        = 8,
  parameter int ACCW     = 32,
  parameter int T        = 16,
  parameter int SIGNED_M = 1,
  parameter int PIPE_MUL = 0
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [T*W-1:0]        a_in_row,
  input  logic [T-1:0]          a_in_valid,
  input  logic [T*W-1:0]        b_in_col,
  input  logic [T-1:0]          b_in_valid,
  input  logic                  acc_clear_block,
  input  logic                  drain_pulse,
  output logic [T*T*ACCW-1:0]   acc_mat,
  output logic [T*T-1:0]        acc_v_mat
);

  localparam int   PW  = 2 * W;
  localparam logic SGN = (SIGNED_M != 0);

  // Forward registers exist only where a neighbour consumes them.
  logic [T*(T-1)*W-1:0] a_fwd_w;
  logic [T*(T-1)-1:0]   a_vfwd_w;
  logic [(T-1)*T*W-1:0] b_fwd_w;
  logic [(T-1)*T-1:0]   b_vfwd_w;
  logic                 v_q;

  genvar gi, gj;
  generate
    for (gi = 0; gi < T; gi++) begin : g_row
      for (gj = 0; gj < T; gj++) begin : g_col
        logic [W-1:0]    a_op, b_op;
        logic            a_v, b_v;
        logic [PW-1:0]   a_ext, b_ext, prod;
        logic [ACCW-1:0] prod_ext, mac_val, acc_q, acc_d, snap_q;
        logic            mac_v;

        if (gj == 0) begin : g_a_in
          assign a_op = a_in_row[gi*W +: W];
          assign a_v  = a_in_valid[gi];
        end else begin : g_a_nb
          assign a_op = a_fwd_w[(gi*(T-1)+gj-1)*W +: W];
          assign a_v  = a_vfwd_w[gi*(T-1)+gj-1];
        end

        if (gi == 0) begin : g_b_in
          assign b_op = b_in_col[gj*W +: W];
          assign b_v  = b_in_valid[gj];
        end else begin : g_b_nb
          assign b_op = b_fwd_w[((gi-1)*T+gj)*W +: W];
          assign b_v  = b_vfwd_w[(gi-1)*T+gj];
        end

        // Low 2W bits of a 2W x 2W product are exact for both signed and unsigned.
        assign a_ext    = {{W{SGN & a_op[W-1]}}, a_op};
        assign b_ext    = {{W{SGN & b_op[W-1]}}, b_op};
        assign prod     = a_ext * b_ext;
        assign prod_ext = {{(ACCW-PW){SGN & prod[PW-1]}}, prod};

        if (gj < T-1) begin : g_a_out
          logic [W-1:0] a_q;
          logic         a_v_q;
          always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
              a_q   <= '0;
              a_v_q <= 1'b0;
            end else begin
              a_q   <= a_op;
              a_v_q <= a_v;
            end
          end
          assign a_fwd_w[(gi*(T-1)+gj)*W +: W] = a_q;
          assign a_vfwd_w[gi*(T-1)+gj]         = a_v_q;
        end

        if (gi < T-1) begin : g_b_out
          logic [W-1:0] b_q;
          logic         b_v_q;
          always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
              b_q   <= '0;
              b_v_q <= 1'b0;
            end else begin
              b_q   <= b_op;
              b_v_q <= b_v;
            end
          end
          assign b_fwd_w[(gi*T+gj)*W +: W] = b_q;
          assign b_vfwd_w[gi*T+gj]         = b_v_q;
        end

        if (PIPE_MUL != 0) begin : g_pipe
          logic [ACCW-1:0] prod_q;
          logic            pv_q;
          // Clear discards both the staged product and the one entering the stage.
          always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
              prod_q <= '0;
              pv_q   <= 1'b0;
            end else if (acc_clear_block) begin
              prod_q <= '0;
              pv_q   <= 1'b0;
            end else begin
              prod_q <= prod_ext;
              pv_q   <= a_v & b_v;
            end
          end
          assign mac_v   = pv_q;
          assign mac_val = prod_q;
        end else begin : g_direct
          assign mac_v   = a_v & b_v;
          assign mac_val = prod_ext;
        end

        always_comb begin
          acc_d = acc_q;
          if (acc_clear_block) acc_d = '0;
          else if (mac_v)      acc_d = acc_q + mac_val;
        end

        always_ff @(posedge clk or posedge rst) begin
          if (rst) begin
            acc_q  <= '0;
            snap_q <= '0;
          end else begin
            acc_q <= acc_d;
            if (drain_pulse) snap_q <= acc_q;
          end
        end

        assign acc_mat[(gi*T+gj)*ACCW +: ACCW] = snap_q;
      end
    end
  endgenerate

  // All snapshot flags move together; drain wins over clear.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)                  v_q <= 1'b0;
    else if (drain_pulse)     v_q <= 1'b1;
    else if (acc_clear_block) v_q <= 1'b0;
  end

  assign acc_v_mat = {(T*T){v_q}};

endmodule

// File: tb/tb_systolic_pe_array.sv
// Directed bench for systolic_pe_array: three instances (signed, unsigned,
// signed with multiplier pipeline) share one skewed stimulus stream.
module tb_systolic_pe_array;
  localparam int T  = 16;
  localparam int W  = 8;
  localparam int AW = 32;

  logic clk = 1'b0;
  logic rst;
  logic [T*W-1:0] a_row, b_col;
  logic [T-1:0]   a_v, b_v;
  logic           clr, drain;
  logic [T*T*AW-1:0] m_s, m_u, m_p;
  logic [T*T-1:0]    v_s, v_u, v_p;

  logic [7:0] am [T][T];
  logic [7:0] bm [T][T];
  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  systolic_pe_array #(.W(W), .ACCW(AW), .T(T), .SIGNED_M(1), .PIPE_MUL(0)) dut_s (
    .clk(clk), .rst(rst), .a_in_row(a_row), .a_in_valid(a_v), .b_in_col(b_col),
    .b_in_valid(b_v), .acc_clear_block(clr), .drain_pulse(drain),
    .acc_mat(m_s), .acc_v_mat(v_s));
  systolic_pe_array #(.W(W), .ACCW(AW), .T(T), .SIGNED_M(0), .PIPE_MUL(0)) dut_u (
    .clk(clk), .rst(rst), .a_in_row(a_row), .a_in_valid(a_v), .b_in_col(b_col),
    .b_in_valid(b_v), .acc_clear_block(clr), .drain_pulse(drain),
    .acc_mat(m_u), .acc_v_mat(v_u));
  systolic_pe_array #(.W(W), .ACCW(AW), .T(T), .SIGNED_M(1), .PIPE_MUL(1)) dut_p (
    .clk(clk), .rst(rst), .a_in_row(a_row), .a_in_valid(a_v), .b_in_col(b_col),
    .b_in_valid(b_v), .acc_clear_block(clr), .drain_pulse(drain),
    .acc_mat(m_p), .acc_v_mat(v_p));

  function automatic logic [31:0] el(input logic [T*T*AW-1:0] m, input int i, input int j);
    return m[(i*T+j)*AW +: AW];
  endfunction

  // Reference dot product of A row i and B column j for one tile.
  function automatic logic [31:0] model(input int i, input int j, input bit sgn);
    logic [31:0] s, av, bv;
    s = 32'd0;
    for (int k = 0; k < T; k++) begin
      av = sgn ? {{24{am[i][k][7]}}, am[i][k]} : {24'd0, am[i][k]};
      bv = sgn ? {{24{bm[k][j][7]}}, bm[k][j]} : {24'd0, bm[k][j]};
      s  = s + av * bv;
    end
    return s;
  endfunction

  task automatic set_identity();
    for (int r = 0; r < T; r++)
      for (int c = 0; c < T; c++) begin
        am[r][c] = (r == c) ? 8'd1 : 8'd0;
        bm[r][c] = 8'((16*r + c + 1) & 8'h7F);
      end
  endtask

  task automatic set_const(input logic [7:0] av, input logic [7:0] bv);
    for (int r = 0; r < T; r++)
      for (int c = 0; c < T; c++) begin
        am[r][c] = av;
        bm[r][c] = bv;
      end
  endtask

  // Skewed tile: A row i element k on cycle k+i, B column j element k on cycle k+j.
  task automatic stream_tile(input int clear_at, input int stop_at);
    for (int c = 0; c < 3*T-2; c++) begin
      if (c == stop_at) break;
      for (int i = 0; i < T; i++) begin
        int k;
        k = c - i;
        a_v[i] = (k >= 0 && k < T);
        a_row[i*W +: W] = a_v[i] ? am[i][k] : 8'd0;
        b_v[i] = (k >= 0 && k < T);
        b_col[i*W +: W] = b_v[i] ? bm[k][i] : 8'd0;
      end
      clr = (c == clear_at);
      @(negedge clk);
    end
    a_v = '0; b_v = '0; a_row = '0; b_col = '0; clr = 1'b0;
  endtask

  task automatic do_drain();
    drain = 1'b1;
    @(negedge clk);
    drain = 1'b0;
  endtask

  task automatic do_clear();
    clr = 1'b1;
    @(negedge clk);
    clr = 1'b0;
  endtask

  task automatic test_reset();
    checks++;
    if (m_s !== '0 || m_u !== '0 || m_p !== '0) begin
      failures++;
      $display("FAIL reset_acc_mat got s=%0h u=%0h p=%0h exp=0", m_s[31:0], m_u[31:0], m_p[31:0]);
    end
    checks++;
    if ({v_s, v_u, v_p} !== '0) begin
      failures++;
      $display("FAIL reset_acc_v got s=%0h u=%0h p=%0h exp=0", v_s, v_u, v_p);
    end
    $display("test_reset done");
  endtask

  task automatic test_identity();
    set_identity();
    stream_tile(-1, -1);
    repeat (5) @(negedge clk);
    do_drain();
    for (int i = 0; i < T; i++)
      for (int j = 0; j < T; j++) begin
        checks++;
        if (el(m_s, i, j) !== model(i, j, 1'b1) || el(m_u, i, j) !== model(i, j, 1'b0) ||
            el(m_p, i, j) !== model(i, j, 1'b1)) begin
          failures++;
          $display("FAIL identity [%0d][%0d] got s=%0h u=%0h p=%0h exp=%0h", i, j,
                   el(m_s, i, j), el(m_u, i, j), el(m_p, i, j), model(i, j, 1'b1));
        end
      end
    checks++;
    if (el(m_s, 0, 0) !== 32'd1 || el(m_s, 15, 15) !== 32'd0) begin
      failures++;
      $display("FAIL identity_corners got [0][0]=%0h [15][15]=%0h exp=1,0", el(m_s, 0, 0), el(m_s, 15, 15));
    end
    checks++;
    if (v_s !== '1 || v_u !== '1 || v_p !== '1) begin
      failures++;
      $display("FAIL identity_valid got s=%0h u=%0h p=%0h exp=all ones", v_s, v_u, v_p);
    end
    $display("test_identity done");
  endtask

  task automatic test_signed();
    do_clear();
    set_const(8'hFF, 8'h02);
    stream_tile(-1, -1);
    repeat (5) @(negedge clk);
    do_drain();
    for (int i = 0; i < T; i++)
      for (int j = 0; j < T; j++) begin
        checks++;
        if (el(m_s, i, j) !== 32'hFFFFFFE0 || el(m_p, i, j) !== 32'hFFFFFFE0 ||
            el(m_u, i, j) !== 32'd8160) begin
          failures++;
          $display("FAIL signed_unsigned [%0d][%0d] got s=%0h p=%0h u=%0d exp s=ffffffe0 u=8160",
                   i, j, el(m_s, i, j), el(m_p, i, j), el(m_u, i, j));
        end
      end
    $display("test_signed done");
  endtask

  task automatic test_multi_tile();
    do_clear();
    set_const(8'd1, 8'd1);
    for (int t = 0; t < 4; t++) begin
      stream_tile(-1, -1);
      repeat (5) @(negedge clk);
    end
    do_drain();
    for (int i = 0; i < T; i++)
      for (int j = 0; j < T; j++) begin
        checks++;
        if (el(m_s, i, j) !== 32'd64 || el(m_u, i, j) !== 32'd64 || el(m_p, i, j) !== 32'd64) begin
          failures++;
          $display("FAIL multi_tile [%0d][%0d] got s=%0d u=%0d p=%0d exp=64", i, j,
                   el(m_s, i, j), el(m_u, i, j), el(m_p, i, j));
        end
      end
    // Clear and drain together: snapshot sees the pre-clear value, flag stays set.
    clr = 1'b1; drain = 1'b1;
    @(negedge clk);
    clr = 1'b0; drain = 1'b0;
    checks++;
    if (el(m_s, 7, 9) !== 32'd64 || v_s !== '1 || v_p !== '1) begin
      failures++;
      $display("FAIL clear_with_drain got acc=%0d v=%0h exp acc=64 v=all ones", el(m_s, 7, 9), v_s);
    end
    do_drain();
    checks++;
    if (m_s !== '0 || m_u !== '0 || m_p !== '0 || v_s !== '1) begin
      failures++;
      $display("FAIL drain_after_clear got acc=%0d v=%0h exp acc=0 v=all ones", el(m_s, 3, 4), v_s);
    end
    do_clear();
    checks++;
    if (v_s !== '0 || v_u !== '0 || v_p !== '0) begin
      failures++;
      $display("FAIL clear_drops_valid got s=%0h u=%0h p=%0h exp=0", v_s, v_u, v_p);
    end
    $display("test_multi_tile done");
  endtask

  task automatic test_clear_collision();
    set_const(8'd1, 8'd1);
    stream_tile(0, -1);
    repeat (5) @(negedge clk);
    do_drain();
    for (int i = 0; i < T; i++)
      for (int j = 0; j < T; j++) begin
        logic [31:0] exp_v;
        exp_v = (i == 0 && j == 0) ? 32'd15 : 32'd16;
        checks++;
        if (el(m_s, i, j) !== exp_v || el(m_u, i, j) !== exp_v) begin
          failures++;
          $display("FAIL clear_collision [%0d][%0d] got s=%0d u=%0d exp=%0d", i, j,
                   el(m_s, i, j), el(m_u, i, j), exp_v);
        end
      end
    $display("test_clear_collision done");
  endtask

  task automatic test_pipe_early();
    do_clear();
    set_const(8'd1, 8'd1);
    stream_tile(-1, -1);
    do_drain();
    checks++;
    if (el(m_s, 15, 15) !== 32'd16) begin
      failures++;
      $display("FAIL early_drain_nopipe got=%0d exp=16", el(m_s, 15, 15));
    end
    checks++;
    if (el(m_p, 15, 15) !== 32'd15) begin
      failures++;
      $display("FAIL early_drain_pipe_last got=%0d exp=15", el(m_p, 15, 15));
    end
    checks++;
    if (el(m_p, 0, 0) !== 32'd16) begin
      failures++;
      $display("FAIL early_drain_pipe_first got=%0d exp=16", el(m_p, 0, 0));
    end
    do_drain();
    checks++;
    if (el(m_p, 15, 15) !== 32'd16) begin
      failures++;
      $display("FAIL late_drain_pipe got=%0d exp=16", el(m_p, 15, 15));
    end
    $display("test_pipe_early done");
  endtask

  task automatic test_reset_mid();
    set_identity();
    stream_tile(-1, 20);
    #2 rst = 1'b1;
    #1;
    checks++;
    if (m_s !== '0 || m_u !== '0 || m_p !== '0 || {v_s, v_u, v_p} !== '0) begin
      failures++;
      $display("FAIL async_reset got s=%0h p=%0h v=%0h exp=0", el(m_s, 0, 0), el(m_p, 0, 0), v_s);
    end
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    stream_tile(-1, -1);
    repeat (5) @(negedge clk);
    do_drain();
    for (int i = 0; i < T; i++)
      for (int j = 0; j < T; j++) begin
        checks++;
        if (el(m_s, i, j) !== model(i, j, 1'b1) || el(m_p, i, j) !== model(i, j, 1'b1)) begin
          failures++;
          $display("FAIL post_reset_identity [%0d][%0d] got s=%0h p=%0h exp=%0h", i, j,
                   el(m_s, i, j), el(m_p, i, j), model(i, j, 1'b1));
        end
      end
    $display("test_reset_mid done");
  endtask

  initial begin
    rst = 1'b1; clr = 1'b0; drain = 1'b0;
    a_row = '0; b_col = '0; a_v = '0; b_v = '0;
    repeat (2) @(negedge clk);
    test_reset();
    rst = 1'b0;
    @(negedge clk);
    test_identity();
    test_signed();
    test_multi_tile();
    test_clear_collision();
    test_pipe_early();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/systolic_pe_array.md
# systolic_pe_array

Output-stationary T×T systolic multiply-accumulate array: the compute core of the tiled matrix-multiply datapath between the operand BRAM banks (A rows, B columns) and the result store. Row-skewed A operands flow east and column-skewed B operands flow south. Each PE(i,j) accumulates the dot product of A row i and B column j across any number of K tiles. A drain pulse snapshots all T×T accumulators onto a parallel result bus for write-back.

## Interface
Parameters:
- W, 8: operand width in bits.
- ACCW, 32: accumulator and result width in bits.
- T, 16: array dimension (T×T PEs).
- SIGNED_M, 1: 1 = operands are two's-complement signed; 0 = unsigned.
- PIPE_MUL, 0: 1 = one register stage between the multiplier and the accumulator.

Ports (one clock; reset is asynchronous and active-high):
- clk, in, 1: rising-edge clock.
- rst, in, 1: asynchronous active-high reset.
- a_in_row, in, T×W: A operand per row; element i feeds PE(i,0).
- a_in_valid, in, T: per-row qualifier for a_in_row.
- b_in_col, in, T×W: B operand per column; element j feeds PE(0,j).
- b_in_valid, in, T: per-column qualifier for b_in_col.
- acc_clear_block, in, 1: synchronous clear of all accumulators.
- drain_pulse, in, 1: one-cycle request to snapshot all accumulators to acc_mat.
- acc_mat, out, T×T×ACCW: registered result snapshot; element [i][j] comes from PE(i,j).
- acc_v_mat, out, T×T: per-PE snapshot-valid flags.

## Operation
- Operand path in PE(i,j):
  - a operand and a_valid come from a_in_row[i]/a_in_valid[i] when j=0, otherwise from the forward registers of PE(i,j-1).
  - b operand and b_valid come from b_in_col[j]/b_in_valid[j] when i=0, otherwise from the forward registers of PE(i-1,j).
  - Each PE registers its (a, a_valid) eastward and its (b, b_valid) southward every cycle, unconditionally.
- MAC:
  - When a_valid & b_valid: acc += a×b.
  - Product is full 2W bits, sign-extended (SIGNED_M=1) or zero-extended (SIGNED_M=0) to ACCW.
  - Accumulation wraps modulo 2^ACCW; there is no saturation.
  - If either valid is low, acc holds.
- Accumulators persist across K tiles until acc_clear_block. Repeated streams therefore sum, which implements K = n·T.
- Clear: acc_clear_block=1 zeroes every acc on that edge. Clear has priority over any product arriving the same cycle, which is discarded. With PIPE_MUL=1 the pending pipeline product is also discarded.
- Drain: drain_pulse=1 loads acc_mat[i][j] ← acc(i,j) as the value before this edge's update, and sets all acc_v_mat bits. acc_mat holds until the next drain.
- acc_v_mat clears to 0 on acc_clear_block (unless drain_pulse is asserted the same cycle, in which case drain wins for acc_v_mat while acc still clears).
- Drain does not modify accumulators.
- Expected stimulus skew: A row i element k on cycle k+i; B column j element k on cycle k+j. Both then meet at PE(i,j) on cycle k+i+j.

## Timing
- Reset: every accumulator, forward register, valid bit, PIPE_MUL stage, acc_mat and acc_v_mat = 0. Reset asserted mid-stream aborts all partial sums.
- PE(i,j) sees an operand injected at cycle t after j cycles (A) or i cycles (B).
- Accumulate edge for a matched pair meeting at PE(i,j) in cycle c: edge ending cycle c (PIPE_MUL=0) or c+1 (PIPE_MUL=1).
- A full T-deep skewed tile occupies 3T-2 input cycles. The last contribution lands in PE(T-1,T-1) at input cycle 3T-3 (+PIPE_MUL).
- drain_pulse must follow that edge to include all contributions. acc_mat/acc_v_mat update on the drain edge, visible the next cycle.
- Gaps (valid=0 cycles) between or inside tiles are legal and contribute nothing.
- Mismatched valids (one side valid only) contribute nothing. The operand still propagates.

## Test plan
- T=16 tile, identity A, B[r][c]=(16r+c+1)&0x7F, skewed stream, wait 5, drain → acc_mat[i][j]=B[i][j] (e.g. [0][0]=1, [15][15]=0x7F&256=0), all acc_v_mat=1.
- SIGNED_M=1: all A=-1 (0xFF), all B=2, one tile → every acc_mat = -32 (0xFFFFFFE0). SIGNED_M=0 same data → every acc_mat = 16×510 = 8160.
- Four consecutive tiles of all-ones A/B with no clear between them, 5 idle cycles apart → every acc_mat = 64. Then clear, drain → 0, with acc_v_mat=1.
- acc_clear_block asserted in the same cycle as a valid product reaches PE(0,0) → that product is excluded; the following products still accumulate.
- PIPE_MUL=1: identity test passes with the drain delayed one extra cycle; a drain issued one cycle early misses the PE(15,15) term.
- Assert rst mid-tile → all outputs 0 immediately (async). After release, a fresh identity tile gives correct results.
